// File: rtl/red_pitaya_daisy_tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// red_pitaya_daisy_pkg
//   Shared definitions for the daisy-chain TX scheduler: state encodings,
//   header layout and the default link-training word.
//   Header word layout: [15:12] marker 4'hA, [11:8] channel, [7:0] len-1.
// ---------------------------------------------------------------------------
package red_pitaya_daisy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_HDR   = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    localparam logic [3:0]  HDR_MARK      = 4'hA;
    localparam logic [15:0] TRAIN_PAT_DEF = 16'h00FF;

    localparam int HDR_MARK_LSB = 12;
    localparam int HDR_CH_LSB   = 8;
    localparam int HDR_LEN_LSB  = 0;

    // Build a burst header from the granted channel and (burst length - 1).
    function automatic logic [15:0] make_hdr(input logic [3:0] ch,
                                             input logic [7:0] len_m1);
        logic [15:0] w;
        w = '0;
        w[HDR_MARK_LSB +: 4] = HDR_MARK;
        w[HDR_CH_LSB   +: 4] = ch;
        w[HDR_LEN_LSB  +: 8] = len_m1;
        return w;
    endfunction

endpackage

// File: rtl/red_pitaya_daisy_tx_sched_if.sv
// ---------------------------------------------------------------------------
// red_pitaya_daisy_tx_sched_if
//   16-bit parallel word link from the scheduler to the TX serializer.
//   Handshake: a word transfers on a clock edge where dv && rdy. The master
//   holds dat stable while dv is high and rdy is low; dv never depends on rdy
//   combinationally. rdy may toggle freely (the serializer raises it one cycle
//   in four).
//   Signals: dv (word valid), dat (16-bit word), rdy (serializer ready).
// ---------------------------------------------------------------------------
interface red_pitaya_daisy_tx_sched_if;
    import red_pitaya_daisy_pkg::*;

    logic        dv;
    logic [15:0] dat;
    logic        rdy;

    modport master (output dv, output dat, input rdy);
    modport slave  (input dv, input dat, output rdy);

endinterface

// File: rtl/red_pitaya_daisy_tx_sched_rr_arb.sv
// ---------------------------------------------------------------------------
// red_pitaya_daisy_rr_arb
//   Combinational round-robin pick: the first set bit of req at or after ptr,
//   wrapping past NCH-1 back to 0.
//   Ports: req (NCH request bits), ptr (search start index),
//          grant (winning index, 0 when none), any (at least one request).
// ---------------------------------------------------------------------------
module red_pitaya_daisy_rr_arb
    import red_pitaya_daisy_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [IW-1:0]  grant,
    output logic           any
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        sum   = '0;
        idx   = '0;
        // One extra bit on sum so ptr+i can be wrapped modulo NCH for any NCH.
        for (int i = 0; i < NCH; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NCH)) begin
                sum = sum - (IW+1)'(NCH);
            end
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/red_pitaya_daisy_tx_sched.sv
// ---------------------------------------------------------------------------
// red_pitaya_daisy_tx_sched
//   Feeds the daisy-chain TX serializer. Shares the link between NCH stream
//   requesters with round-robin bursts (header word + len data words), or
//   sends TRAIN_PAT continuously while link training is requested.
//   Ports:
//     par_clk_i, par_rstn_i   clock, async active-low reset
//     cfg_en_i                enable scheduling of new bursts
//     cfg_train_i             send training pattern
//     cfg_burst_i             data words per burst (0 means 1)
//     req_dv_i/req_dat_i/req_rdy_o  requester streams (dv && rdy = accept)
//     tx                      word link to serializer (master side)
//     stat_state_o            current FSM state
//     stat_words_o            data words handed to the serializer (wraps)
// ---------------------------------------------------------------------------
module red_pitaya_daisy_tx_sched
    import red_pitaya_daisy_pkg::*;
#(
    parameter int          NCH       = 2,
    parameter logic [15:0] TRAIN_PAT = TRAIN_PAT_DEF
) (
    input  logic                      par_clk_i,
    input  logic                      par_rstn_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_train_i,
    input  logic [7:0]                cfg_burst_i,
    input  logic [NCH-1:0]            req_dv_i,
    input  logic [16*NCH-1:0]         req_dat_i,
    output logic [NCH-1:0]            req_rdy_o,
    red_pitaya_daisy_tx_sched_if.master tx,
    output logic [1:0]                stat_state_o,
    output logic [31:0]               stat_words_o
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t        state_q, state_nx;
    logic [IW-1:0] grant_q, grant_nx;
    logic [IW-1:0] ptr_q, ptr_nx;
    logic [7:0]    len_q, len_nx;
    logic [7:0]    cnt_q, cnt_nx;
    logic          dv_q, dv_nx;
    logic [15:0]   dat_q, dat_nx;
    logic [31:0]   words_q, words_nx;

    logic [IW-1:0] arb_grant;
    logic          arb_any;
    logic          free;
    logic [15:0]   req_words [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_words
        assign req_words[k] = req_dat_i[16*k +: 16];
    end

    red_pitaya_daisy_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .req   (req_dv_i),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .any   (arb_any)
    );

    // The output register may take a new word when empty or being drained.
    assign free = !dv_q || tx.rdy;

    always_comb begin
        state_nx  = state_q;
        grant_nx  = grant_q;
        ptr_nx    = ptr_q;
        len_nx    = len_q;
        cnt_nx    = cnt_q;
        dv_nx     = dv_q;
        dat_nx    = dat_q;
        words_nx  = words_q;
        req_rdy_o = '0;

        // A drained register that nothing reloads goes invalid.
        if (free) begin
            dv_nx = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_train_i) begin
                    state_nx = ST_TRAIN;
                end else if (cfg_en_i && arb_any) begin
                    grant_nx = arb_grant;
                    len_nx   = (cfg_burst_i == 8'd0) ? 8'd1 : cfg_burst_i;
                    state_nx = ST_HDR;
                end
            end
            ST_TRAIN: begin
                // Only leave on a word boundary so no pattern word is cut.
                if (free) begin
                    if (cfg_train_i) begin
                        dv_nx  = 1'b1;
                        dat_nx = TRAIN_PAT;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_HDR: begin
                if (free) begin
                    dv_nx    = 1'b1;
                    dat_nx   = make_hdr(4'(grant_q), len_q - 8'd1);
                    cnt_nx   = 8'd0;
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                req_rdy_o[grant_q] = free;
                if (free && req_dv_i[grant_q]) begin
                    dv_nx    = 1'b1;
                    dat_nx   = req_words[grant_q];
                    cnt_nx   = cnt_q + 8'd1;
                    words_nx = words_q + 32'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_nx = ST_IDLE;
                        ptr_nx   = (grant_q == IW'(NCH-1)) ? '0 : grant_q + IW'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
        if (!par_rstn_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            len_q   <= 8'd1;
            cnt_q   <= 8'd0;
            dv_q    <= 1'b0;
            dat_q   <= 16'd0;
            words_q <= 32'd0;
        end else begin
            state_q <= state_nx;
            grant_q <= grant_nx;
            ptr_q   <= ptr_nx;
            len_q   <= len_nx;
            cnt_q   <= cnt_nx;
            dv_q    <= dv_nx;
            dat_q   <= dat_nx;
            words_q <= words_nx;
        end
    end

    assign tx.dv        = dv_q;
    assign tx.dat       = dat_q;
    assign stat_state_o = state_q;
    assign stat_words_o = words_q;

endmodule

// File: tb/tb_red_pitaya_daisy_tx_sched.sv
module tb_red_pitaya_daisy_tx_sched;

    localparam int NCH = 2;

    logic              par_clk_i;
    logic              par_rstn_i;
    logic              cfg_en_i;
    logic              cfg_train_i;
    logic [7:0]        cfg_burst_i;
    logic [NCH-1:0]    req_dv_i;
    logic [16*NCH-1:0] req_dat_i;
    logic [NCH-1:0]    req_rdy_o;
    logic [1:0]        stat_state_o;
    logic [31:0]       stat_words_o;

    red_pitaya_daisy_tx_sched_if tx_if ();

    red_pitaya_daisy_tx_sched #(.NCH(NCH), .TRAIN_PAT(16'h00FF)) dut (
        .par_clk_i    (par_clk_i),
        .par_rstn_i   (par_rstn_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_train_i  (cfg_train_i),
        .cfg_burst_i  (cfg_burst_i),
        .req_dv_i     (req_dv_i),
        .req_dat_i    (req_dat_i),
        .req_rdy_o    (req_rdy_o),
        .tx           (tx_if),
        .stat_state_o (stat_state_o),
        .stat_words_o (stat_words_o)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];          // expected link words, in order
    logic [15:0] src_q[NCH][$];     // words each source still has to offer
    logic [15:0] mq[NCH][$];        // model copy, consumed by build_expect
    int          m_ptr = 0;         // model round-robin pointer
    logic [31:0] exp_words = 0;     // model data-word count

    int acc[NCH];
    int stall_cnt[NCH];
    int stall_at[NCH];
    int stall_len = 0;
    int cur_len = 1;
    bit rand_stall = 0;
    bit allow_train = 0;
    int train_seen = 0;
    int gap_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- clock / reset / serializer ----------------
    initial begin
        par_clk_i = 1'b0;
        forever #5 par_clk_i = ~par_clk_i;
    end

    initial begin
        int phase;
        phase = 0;
        tx_if.rdy = 1'b0;
        forever begin
            @(posedge par_clk_i);
            #1;
            phase = (phase + 1) % 4;
            tx_if.rdy = (phase == 3);
        end
    end

    // ---------------- source driver ----------------
    initial begin
        logic [NCH-1:0] hs;
        req_dv_i  = '0;
        req_dat_i = '0;
        for (int k = 0; k < NCH; k++) begin
            acc[k] = 0; stall_cnt[k] = 0; stall_at[k] = -1;
        end
        forever begin
            @(negedge par_clk_i);
            hs = req_dv_i & req_rdy_o;
            @(posedge par_clk_i);
            #1;
            for (int k = 0; k < NCH; k++) begin
                if (hs[k] && src_q[k].size() > 0) begin
                    void'(src_q[k].pop_front());
                    acc[k]++;
                    // Stalls only inside a burst, so every channel holding
                    // data is valid whenever the scheduler picks a winner.
                    if (acc[k] == stall_at[k])
                        stall_cnt[k] = stall_len;
                    else if (rand_stall && (acc[k] % cur_len) != 0 && $urandom_range(0, 3) == 0)
                        stall_cnt[k] = $urandom_range(1, 6);
                end
                if (stall_cnt[k] > 0) begin
                    req_dv_i[k] = 1'b0;
                    stall_cnt[k]--;
                end else if (src_q[k].size() > 0) begin
                    req_dv_i[k] = 1'b1;
                    req_dat_i[16*k +: 16] = src_q[k][0];
                end else begin
                    req_dv_i[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic add_word(input int k, input logic [15:0] w);
        src_q[k].push_back(w);
        mq[k].push_back(w);
    endtask

    task automatic add_rand(input int k, input int n);
        for (int i = 0; i < n; i++) add_word(k, 16'($urandom_range(0, 16'hFFFF)));
    endtask

    // Link schedule from the rules: each burst goes to the first channel at or
    // after the pointer that still has words, header first, then len words.
    task automatic build_expect(input int burst_cfg);
        int len;
        int c;
        bit found;
        len = (burst_cfg == 0) ? 1 : burst_cfg;
        cur_len = len;
        for (int k = 0; k < NCH; k++) acc[k] = 0;
        forever begin
            found = 0;
            c = 0;
            for (int i = 0; i < NCH; i++) begin
                if (!found && mq[(m_ptr + i) % NCH].size() > 0) begin
                    found = 1;
                    c = (m_ptr + i) % NCH;
                end
            end
            if (!found) break;
            exp_q.push_back({4'hA, 4'(c), 8'(len - 1)});
            for (int j = 0; j < len; j++) begin
                exp_q.push_back(mq[c].pop_front());
                exp_words = exp_words + 32'd1;
            end
            m_ptr = (c + 1) % NCH;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        bit busy;
        n = 0;
        busy = 1;
        while (busy && n < 3000) begin
            busy = (exp_q.size() != 0);
            for (int k = 0; k < NCH; k++) if (src_q[k].size() != 0) busy = 1;
            if (busy) begin
                @(negedge par_clk_i);
                n++;
            end
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_drain: timeout with %0d words outstanding", name, exp_q.size());
        end
        repeat (4) @(negedge par_clk_i);
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int n;
        n = 0;
        while (stat_state_o !== s && n < 500) begin
            @(negedge par_clk_i);
            n++;
        end
        chk(name, 32'(stat_state_o), 32'(s));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge par_clk_i);
            if (par_rstn_i) begin
                if (stat_state_o == 2'd3 && !tx_if.dv) gap_cycles++;
                if (tx_if.dv && tx_if.rdy) begin
                    if (exp_q.size() > 0) begin
                        exp = exp_q.pop_front();
                        chk("link_word", 32'(tx_if.dat), 32'(exp));
                    end else if (allow_train) begin
                        chk("train_word", 32'(tx_if.dat), 32'h0000_00FF);
                        train_seen++;
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %04h expected none", tx_if.dat);
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        logic [31:0] w0;
        par_rstn_i  = 1'b0;
        cfg_en_i    = 1'b1;
        cfg_train_i = 1'b0;
        cfg_burst_i = 8'd2;

        // Reset with both requesters valid, then round robin, burst 2.
        @(negedge par_clk_i);
        add_rand(0, 6);
        add_rand(1, 6);
        build_expect(2);
        repeat (4) @(negedge par_clk_i);
        chk("rst_dv", 32'(tx_if.dv), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy_o), 32'd0);
        chk("rst_words", stat_words_o, 32'd0);
        chk("rst_state", 32'(stat_state_o), 32'd0);
        chk("rst_req_dv_held", 32'(req_dv_i), 32'd3);
        rand_stall = 1;
        par_rstn_i = 1'b1;
        wait_drain("rr");
        chk("rr_words", stat_words_o, exp_words);

        // Single burst on ch1 only.
        rand_stall = 0;
        cfg_burst_i = 8'd3;
        add_word(1, 16'h1111);
        add_word(1, 16'h2222);
        add_word(1, 16'h3333);
        build_expect(3);
        wait_drain("single");
        chk("single_words", stat_words_o, exp_words);

        // ch0 stalls 10 cycles after two words of a 4-word burst.
        cfg_burst_i = 8'd4;
        stall_at[0] = 2;
        stall_len = 10;
        gap_cycles = 0;
        add_rand(0, 4);
        build_expect(4);
        wait_drain("stall");
        stall_at[0] = -1;
        chk("stall_words", stat_words_o, exp_words);
        checks++;
        if (gap_cycles == 0) begin
            errors++;
            $display("FAIL stall_gap: got 0 gap cycles expected >0");
        end
        chk("stall_idle", 32'(stat_state_o), 32'd0);

        // Randomized rounds.
        rand_stall = 1;
        for (int r = 0; r < 6; r++) begin
            int b;
            b = $urandom_range(0, 5);
            cfg_burst_i = 8'(b);
            for (int k = 0; k < NCH; k++)
                add_rand(k, ((b == 0) ? 1 : b) * $urandom_range(0, 3));
            build_expect(b);
            wait_drain("rand");
            chk("rand_words", stat_words_o, exp_words);
        end
        rand_stall = 0;

        // Training requested mid-burst.
        cfg_burst_i = 8'd3;
        add_word(0, 16'h1234);
        add_word(0, 16'h5678);
        add_word(0, 16'h9ABC);
        build_expect(3);
        allow_train = 1;
        train_seen = 0;
        wait_state(2'd3, "train_reach_data");
        cfg_train_i = 1'b1;
        n = 0;
        while (train_seen < 6 && n < 500) begin
            @(negedge par_clk_i);
            n++;
        end
        chk("train_burst_done", 32'(exp_q.size()), 32'd0);
        chk("train_state", 32'(stat_state_o), 32'd1);
        checks++;
        if (train_seen < 6) begin
            errors++;
            $display("FAIL train_count: got %0d train words expected >=6", train_seen);
        end
        cfg_train_i = 1'b0;
        wait_state(2'd0, "train_exit");
        chk("train_exit_dv", 32'(tx_if.dv), 32'd0);
        allow_train = 0;
        repeat (8) @(negedge par_clk_i);
        chk("train_stays_idle", 32'(stat_state_o), 32'd0);
        chk("train_words", stat_words_o, exp_words);

        // Asynchronous reset in the middle of a burst.
        cfg_burst_i = 8'd6;
        add_rand(0, 6);
        add_rand(1, 6);
        build_expect(6);
        w0 = stat_words_o;
        n = 0;
        while (!(stat_state_o == 2'd3 && stat_words_o >= w0 + 32'd2) && n < 500) begin
            @(negedge par_clk_i);
            n++;
        end
        chk("arst_in_data", 32'(stat_state_o), 32'd3);
        #2;
        par_rstn_i = 1'b0;
        #1;
        chk("arst_dv", 32'(tx_if.dv), 32'd0);
        chk("arst_dat", 32'(tx_if.dat), 32'd0);
        chk("arst_req_rdy", 32'(req_rdy_o), 32'd0);
        chk("arst_state", 32'(stat_state_o), 32'd0);
        chk("arst_words", stat_words_o, 32'd0);
        exp_q.delete();
        for (int k = 0; k < NCH; k++) begin
            src_q[k].delete();
            mq[k].delete();
            stall_cnt[k] = 0;
        end
        m_ptr = 0;
        exp_words = 0;
        repeat (3) @(negedge par_clk_i);
        chk("arst_no_words", 32'(tx_if.dv), 32'd0);
        par_rstn_i = 1'b1;

        // Zero burst length means one word per burst.
        cfg_burst_i = 8'd0;
        add_word(0, 16'h5A5A);
        add_word(1, 16'hBEEF);
        build_expect(0);
        wait_drain("burst0");
        chk("burst0_words", stat_words_o, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
